// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer
//   Multi-cycle instruction fetch / program sequencer. Fetches one
//   instruction from a variable-latency instruction memory, presents it to
//   the execute stage, then advances the PC (sequentially or by a
//   PC-relative branch) once execute retires it. A halting instruction
//   parks the sequencer in DONE until the next start.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous reset, active low
//   start        level; launches, or aborts and relaunches, the program
//   imem_req     high in every FETCH cycle
//   imem_addr    fetch address (always equal to pc)
//   imem_valid   imem_data is valid for the address presented this cycle
//   imem_data    fetched instruction word
//   instr        registered instruction presented to execute
//   instr_valid  high in every ISSUE cycle
//   ex_ready     execute retires instr this cycle
//   br_taken     retiring instruction is a taken branch (with ex_ready)
//   br_off       two's-complement branch offset (with ex_ready)
//   halt         retiring instruction ends the program (with ex_ready)
//   done         program finished
//   pc           current program counter
//   cycle_cnt    saturating count of FETCH+ISSUE cycles since last start
//   instr_cnt    saturating count of retired instructions since last start
//   dbg_state    current FSM state (IDLE=0, FETCH=1, ISSUE=2, DONE=3)
//
// Handshakes
//   Memory side: imem_req is the valid, imem_valid the ready; a fetch
//   completes on the cycle both are high. Execute side: instr_valid is the
//   valid, ex_ready the ready; instr is held stable until the cycle both are
//   high, and br_taken/br_off/halt are only looked at in that cycle.
//   start overrides both handshakes in the cycle it is high.
//
// All outputs come straight from registers or from the state register, so
// there is no combinational path from any input to any output.
// Requires PC_W > OFF_W.
// ---------------------------------------------------------------------------
module fetch_sequencer #(
  parameter int              PC_W     = 12,
  parameter int              INSTR_W  = 9,
  parameter int              OFF_W    = 8,
  parameter logic [PC_W-1:0] START_PC = '0,
  parameter int              CNT_W    = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_valid,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic               ex_ready,
  input  logic               br_taken,
  input  logic [OFF_W-1:0]   br_off,
  input  logic               halt,
  output logic               done,
  output logic [PC_W-1:0]    pc,
  output logic [CNT_W-1:0]   cycle_cnt,
  output logic [CNT_W-1:0]   instr_cnt,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_ISSUE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [CNT_W-1:0]   cyc_q, cyc_d;
  logic [CNT_W-1:0]   icnt_q, icnt_d;

  logic [PC_W-1:0]    pc_seq;
  logic [PC_W-1:0]    br_off_sext;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // PC arithmetic is naturally modulo 2^PC_W; negative offsets wrap because
  // the offset is sign-extended to full PC width before the add.
  assign pc_seq      = pc_q + PC_W'(1);
  assign br_off_sext = {{(PC_W-OFF_W){br_off[OFF_W-1]}}, br_off};

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    cyc_d   = cyc_q;
    icnt_d  = icnt_q;

    if (state_q == S_FETCH || state_q == S_ISSUE) begin
      cyc_d = sat_inc(cyc_q);
    end

    if (start) begin
      // Restart from any state; an in-flight fetch or an instruction being
      // retired this very cycle is dropped and not counted.
      state_d = S_FETCH;
      pc_d    = START_PC;
      cyc_d   = '0;
      icnt_d  = '0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (imem_valid) begin
            instr_d = imem_data;
            state_d = S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (ex_ready) begin
            icnt_d = sat_inc(icnt_q);
            if (halt) begin
              // Halt leaves the PC on the halting instruction.
              state_d = S_DONE;
            end else begin
              state_d = S_FETCH;
              pc_d    = br_taken ? (pc_seq + br_off_sext) : pc_seq;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      pc_q    <= START_PC;
      instr_q <= '0;
      cyc_q   <= '0;
      icnt_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      cyc_q   <= cyc_d;
      icnt_q  <= icnt_d;
    end
  end

  assign imem_req    = (state_q == S_FETCH);
  assign instr_valid = (state_q == S_ISSUE);
  assign done        = (state_q == S_DONE);
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign cycle_cnt   = cyc_q;
  assign instr_cnt   = icnt_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fetch_sequencer
//   Two sequencers share every control input: u0 (START_PC=0x000, 16-bit
//   counters) and u1 (START_PC=0xFFF, 4-bit counters). Their state
//   trajectories are identical; only PCs, fetched words and counter limits
//   differ. Each has its own address-driven memory image.
//   A program-level model (phase, raw PC integers, unbounded raw counts
//   clipped to each counter's maximum) is compared against both DUTs on
//   every falling edge; directed tests add literal checks on fetch address
//   logs and final counter values.
// ---------------------------------------------------------------------------
module tb_fetch_sequencer;

  localparam int PC_W    = 12;
  localparam int INSTR_W = 9;
  localparam int OFF_W   = 8;
  localparam int CNT_W0  = 16;
  localparam int CNT_W1  = 4;
  localparam int NI      = 2;

  localparam int P_IDLE  = 0;
  localparam int P_FETCH = 1;
  localparam int P_ISSUE = 2;
  localparam int P_DONE  = 3;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- DUT signals ----------------
  logic             start, imem_valid, ex_ready, br_taken, halt;
  logic [OFF_W-1:0] br_off;

  logic               req0, iv0, done0;
  logic [PC_W-1:0]    addr0, pc0;
  logic [INSTR_W-1:0] data0, instr0;
  logic [CNT_W0-1:0]  cyc0, icnt0;
  logic [1:0]         st0;

  logic               req1, iv1, done1;
  logic [PC_W-1:0]    addr1, pc1;
  logic [INSTR_W-1:0] data1, instr1;
  logic [CNT_W1-1:0]  cyc1, icnt1;
  logic [1:0]         st1;

  function automatic logic [INSTR_W-1:0] mem_f(input int a);
    int t;
    t = (a * 13 + 7) % 512;
    return t[INSTR_W-1:0];
  endfunction

  assign data0 = mem_f(int'(addr0));
  assign data1 = mem_f(int'(addr1));

  fetch_sequencer #(.PC_W(PC_W), .INSTR_W(INSTR_W), .OFF_W(OFF_W),
                    .START_PC(12'h000), .CNT_W(CNT_W0)) u0 (
    .clk(clk), .reset(rst_n), .start(start),
    .imem_req(req0), .imem_addr(addr0), .imem_valid(imem_valid), .imem_data(data0),
    .instr(instr0), .instr_valid(iv0), .ex_ready(ex_ready),
    .br_taken(br_taken), .br_off(br_off), .halt(halt),
    .done(done0), .pc(pc0), .cycle_cnt(cyc0), .instr_cnt(icnt0), .dbg_state(st0)
  );

  fetch_sequencer #(.PC_W(PC_W), .INSTR_W(INSTR_W), .OFF_W(OFF_W),
                    .START_PC(12'hFFF), .CNT_W(CNT_W1)) u1 (
    .clk(clk), .reset(rst_n), .start(start),
    .imem_req(req1), .imem_addr(addr1), .imem_valid(imem_valid), .imem_data(data1),
    .instr(instr1), .instr_valid(iv1), .ex_ready(ex_ready),
    .br_taken(br_taken), .br_off(br_off), .halt(halt),
    .done(done1), .pc(pc1), .cycle_cnt(cyc1), .instr_cnt(icnt1), .dbg_state(st1)
  );

  // ---------------- checking core ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got 0x%0h want 0x%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_phase;
  int m_pc    [NI];
  int m_instr [NI];
  int raw_cyc, raw_ret;
  int start_pc[NI];
  int cnt_max [NI];

  function automatic int wrap_pc(input int v);
    return ((v % 4096) + 4096) % 4096;
  endfunction

  function automatic int soff(input logic [OFF_W-1:0] o);
    int v;
    v = int'(o);
    if (v >= 128) v = v - 256;
    return v;
  endfunction

  task automatic model_reset();
    m_phase = P_IDLE;
    for (int k = 0; k < NI; k++) begin
      m_pc[k]    = start_pc[k];
      m_instr[k] = 0;
    end
    raw_cyc = 0;
    raw_ret = 0;
  endtask

  initial begin
    start_pc[0] = 0;     start_pc[1] = 'hFFF;
    cnt_max[0]  = 65535; cnt_max[1]  = 15;
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_reset();
      end else begin
        if (m_phase == P_FETCH || m_phase == P_ISSUE) raw_cyc++;
        if (start) begin
          m_phase = P_FETCH;
          for (int k = 0; k < NI; k++) m_pc[k] = start_pc[k];
          raw_cyc = 0;
          raw_ret = 0;
        end else if (m_phase == P_FETCH) begin
          if (imem_valid) begin
            for (int k = 0; k < NI; k++) m_instr[k] = int'(mem_f(m_pc[k]));
            m_phase = P_ISSUE;
          end
        end else if (m_phase == P_ISSUE && ex_ready) begin
          raw_ret++;
          if (halt) begin
            m_phase = P_DONE;
          end else begin
            for (int k = 0; k < NI; k++)
              m_pc[k] = wrap_pc(m_pc[k] + 1 + (br_taken ? soff(br_off) : 0));
            m_phase = P_FETCH;
          end
        end
      end
    end
  end

  task automatic cmp_inst(input int k, input logic [31:0] a_req, input logic [31:0] a_addr,
                          input logic [31:0] a_instr, input logic [31:0] a_iv,
                          input logic [31:0] a_done, input logic [31:0] a_pc,
                          input logic [31:0] a_cyc, input logic [31:0] a_icnt);
    int ec, ei;
    ec = (raw_cyc > cnt_max[k]) ? cnt_max[k] : raw_cyc;
    ei = (raw_ret > cnt_max[k]) ? cnt_max[k] : raw_ret;
    chk($sformatf("u%0d.imem_req", k),    a_req,   32'(m_phase == P_FETCH));
    chk($sformatf("u%0d.instr_valid", k), a_iv,    32'(m_phase == P_ISSUE));
    chk($sformatf("u%0d.done", k),        a_done,  32'(m_phase == P_DONE));
    chk($sformatf("u%0d.pc", k),          a_pc,    32'(m_pc[k]));
    chk($sformatf("u%0d.imem_addr", k),   a_addr,  32'(m_pc[k]));
    chk($sformatf("u%0d.instr", k),       a_instr, 32'(m_instr[k]));
    chk($sformatf("u%0d.cycle_cnt", k),   a_cyc,   32'(ec));
    chk($sformatf("u%0d.instr_cnt", k),   a_icnt,  32'(ei));
  endtask

  initial begin
    forever begin
      @(negedge clk);
      cmp_inst(0, 32'(req0), 32'(addr0), 32'(instr0), 32'(iv0), 32'(done0), 32'(pc0), 32'(cyc0), 32'(icnt0));
      cmp_inst(1, 32'(req1), 32'(addr1), 32'(instr1), 32'(iv1), 32'(done1), 32'(pc1), 32'(cyc1), 32'(icnt1));
    end
  end

  // ---------------- driver: memory and execute responders ----------------
  typedef struct {
    int         lat;    // FETCH cycles until imem_valid
    int         stall;  // ISSUE cycles with ex_ready low before retire
    logic       br;
    logic [7:0] off;
    logic       hlt;
  } desc_t;

  desc_t      prog_q[$];
  desc_t      cur;
  int         f_age, i_age;
  bit         allow_rand_halt;
  logic [31:0] log0[$];
  logic [31:0] log1[$];

  initial begin
    imem_valid = 1'b0; ex_ready = 1'b0; br_taken = 1'b0; br_off = '0; halt = 1'b0;
    f_age = 0; i_age = 0; allow_rand_halt = 1'b0;
    cur = '{lat: 1, stall: 0, br: 1'b0, off: 8'h00, hlt: 1'b0};
    forever begin
      @(negedge clk);
      if (req0 === 1'b1) begin
        if (f_age == 0) begin
          if (prog_q.size() > 0) begin
            cur = prog_q.pop_front();
          end else begin
            cur.lat   = $urandom_range(1, 4);
            cur.stall = $urandom_range(0, 3);
            cur.br    = ($urandom_range(0, 2) == 0);
            cur.off   = 8'($urandom_range(0, 255));
            cur.hlt   = allow_rand_halt && ($urandom_range(0, 7) == 0);
          end
          log0.push_back(32'(addr0));
          log1.push_back(32'(addr1));
        end
        f_age++;
        imem_valid = (f_age >= cur.lat);
      end else begin
        f_age = 0;
        imem_valid = 1'($urandom_range(0, 1));
      end
      if (iv0 === 1'b1) begin
        i_age++;
        ex_ready = (i_age > cur.stall);
        br_taken = cur.br;
        br_off   = cur.off;
        halt     = cur.hlt;
      end else begin
        i_age    = 0;
        ex_ready = 1'($urandom_range(0, 1));
        br_taken = 1'($urandom_range(0, 1));
        br_off   = 8'($urandom_range(0, 255));
        halt     = 1'($urandom_range(0, 1));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic push(input int lat, input int stall, input logic br,
                      input logic [7:0] off, input logic hlt);
    desc_t d;
    d = '{lat: lat, stall: stall, br: br, off: off, hlt: hlt};
    prog_q.push_back(d);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic new_run();
    log0.delete();
    log1.delete();
  endtask

  task automatic wait_done(input int max_cyc, input string tag);
    int n;
    n = 0;
    while (done0 !== 1'b1 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done"}, 32'(done0), 32'd1);
  endtask

  function automatic logic [31:0] lg0(input int i);
    return (i < log0.size()) ? log0[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] lg1(input int i);
    return (i < log1.size()) ? log1[i] : 32'hDEAD_BEEF;
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int n;
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // 1. reset values, then zero-wait three-instruction program
    chk("rst_pc0",    32'(pc0),   32'h000);
    chk("rst_pc1",    32'(pc1),   32'hFFF);
    chk("rst_done",   32'(done0), 32'd0);
    chk("rst_req",    32'(req0),  32'd0);
    chk("rst_iv",     32'(iv0),   32'd0);
    chk("rst_instr",  32'(instr0), 32'd0);
    chk("rst_cyc",    32'(cyc0),  32'd0);
    chk("rst_state0", 32'(st0),   32'd0);
    chk("rst_state1", 32'(st1),   32'd0);
    new_run();
    push(1, 0, 1'b0, 8'h00, 1'b0);
    push(1, 0, 1'b0, 8'h00, 1'b0);
    push(1, 0, 1'b0, 8'h00, 1'b1);
    pulse_start();
    wait_done(100, "t1");
    chk("t1_nfetch", 32'(log0.size()), 32'd3);
    chk("t1_addr0",  lg0(0), 32'h000);
    chk("t1_addr1",  lg0(1), 32'h001);
    chk("t1_addr2",  lg0(2), 32'h002);
    chk("t1_icnt",   32'(icnt0), 32'd3);
    chk("t1_cyc",    32'(cyc0),  32'd6);
    chk("t1_pc",     32'(pc0),   32'h002);
    chk("t1_u1_a0",  lg1(0), 32'hFFF);
    chk("t1_u1_a1",  lg1(1), 32'h000);
    chk("t1_u1_cyc", 32'(cyc1),  32'd6);

    // 2. three-cycle memory, two-cycle execute stall
    new_run();
    push(3, 2, 1'b0, 8'h00, 1'b0);
    push(3, 2, 1'b0, 8'h00, 1'b0);
    push(3, 2, 1'b0, 8'h00, 1'b1);
    pulse_start();
    wait_done(200, "t2");
    chk("t2_cyc",     32'(cyc0),  32'd18);
    chk("t2_icnt",    32'(icnt0), 32'd3);
    chk("t2_u1_cyc",  32'(cyc1),  32'd15);
    chk("t2_u1_icnt", 32'(icnt1), 32'd3);

    // 3. branches: back by 2 from 5, forward by 16 from 4
    new_run();
    for (int i = 0; i < 5; i++) push($urandom_range(1, 2), $urandom_range(0, 1), 1'b0, 8'h00, 1'b0);
    push(1, 0, 1'b1, 8'hFE, 1'b0);
    push(2, 1, 1'b1, 8'h10, 1'b0);
    push(1, 0, 1'b0, 8'h00, 1'b1);
    wait_done(0, "t3_pre_idle_ok") ;
    pulse_start();
    wait_done(300, "t3");
    chk("t3_at5",     lg0(5), 32'h005);
    chk("t3_back",    lg0(6), 32'h004);
    chk("t3_fwd",     lg0(7), 32'h015);
    chk("t3_pc",      32'(pc0), 32'h015);
    chk("t3_icnt",    32'(icnt0), 32'd8);
    chk("t3_u1_back", lg1(6), 32'h003);
    chk("t3_u1_fwd",  lg1(7), 32'h014);

    // 4. wrap: 0xFFF -> 0x000, and 0x001 + 1 - 2 -> 0x000
    new_run();
    push(1, 0, 1'b0, 8'h00, 1'b0);
    push(1, 0, 1'b0, 8'h00, 1'b0);
    push(1, 0, 1'b1, 8'hFE, 1'b0);
    push(1, 0, 1'b0, 8'h00, 1'b1);
    pulse_start();
    wait_done(100, "t4");
    chk("t4_u1_a0", lg1(0), 32'hFFF);
    chk("t4_u1_a1", lg1(1), 32'h000);
    chk("t4_u1_a2", lg1(2), 32'h001);
    chk("t4_u1_a3", lg1(3), 32'h000);
    chk("t4_u0_a3", lg0(3), 32'h001);
    chk("t4_u1_pc", 32'(pc1), 32'h000);

    // 5. start collides with a halting retire
    new_run();
    push(1, 0, 1'b0, 8'h00, 1'b0);
    push(1, 0, 1'b0, 8'h00, 1'b1);
    pulse_start();
    n = 0;
    while (!(iv0 === 1'b1 && icnt0 == 1) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t5_reach_issue", 32'(iv0), 32'd1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t5_done",  32'(done0), 32'd0);
    chk("t5_req",   32'(req0),  32'd1);
    chk("t5_state", 32'(st0),   32'd1);
    chk("t5_pc0",   32'(pc0),   32'h000);
    chk("t5_pc1",   32'(pc1),   32'hFFF);
    chk("t5_icnt",  32'(icnt0), 32'd0);
    chk("t5_cyc",   32'(cyc0),  32'd0);
    allow_rand_halt = 1'b1;
    wait_done(3000, "t5_after");

    // 6. saturation of the 4-bit counters over 20 instructions
    new_run();
    for (int i = 0; i < 19; i++) push(1, 0, 1'b0, 8'h00, 1'b0);
    push(1, 0, 1'b0, 8'h00, 1'b1);
    pulse_start();
    wait_done(200, "t6");
    chk("t6_u1_icnt", 32'(icnt1), 32'd15);
    chk("t6_u1_cyc",  32'(cyc1),  32'd15);
    chk("t6_u0_icnt", 32'(icnt0), 32'd20);
    chk("t6_u0_cyc",  32'(cyc0),  32'd40);

    // 6b. asynchronous reset in the middle of a long fetch
    allow_rand_halt = 1'b0;
    push(1, 0, 1'b0, 8'h00, 1'b0);
    push(1, 0, 1'b0, 8'h00, 1'b0);
    push(4, 0, 1'b0, 8'h00, 1'b0);
    push(4, 0, 1'b0, 8'h00, 1'b0);
    pulse_start();
    n = 0;
    while (!(req0 === 1'b1 && icnt0 >= 2) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t6_reach_fetch", 32'(req0), 32'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_req",   32'(req0),   32'd0);
    chk("ar_iv",    32'(iv0),    32'd0);
    chk("ar_done",  32'(done0),  32'd0);
    chk("ar_pc0",   32'(pc0),    32'h000);
    chk("ar_pc1",   32'(pc1),    32'hFFF);
    chk("ar_cyc",   32'(cyc0),   32'd0);
    chk("ar_icnt",  32'(icnt0),  32'd0);
    chk("ar_instr", 32'(instr0), 32'd0);
    prog_q.delete();
    @(negedge clk);
    rst_n = 1'b1;

    // random programs, with occasional restarts mid-run
    allow_rand_halt = 1'b1;
    for (int r = 0; r < 10; r++) begin
      new_run();
      pulse_start();
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(3, 30)) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      wait_done(4000, $sformatf("rnd%0d", r));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
